// File: rtl/onehot_decoder_pkg.sv
// Shared constants, types and helpers for the binary-to-one-hot decoder
// and its 2-entry output FIFO.
package onehot_decoder_pkg;

  localparam int unsigned SEL_W      = 3;
  localparam int unsigned OUT_W      = 8;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned FIFO_DEPTH = 2;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [OUT_W-1:0] onehot_t;

  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'd0,
    FIFO_ONE   = 2'd1,
    FIFO_FULL  = 2'd2
  } fifo_state_e;

  // Bit s of the result is set, all others clear.
  function automatic onehot_t onehot(input sel_t s);
    onehot_t r;
    r    = '0;
    r[s] = 1'b1;
    return r;
  endfunction

  // Even parity over an index: the matching parity bit makes the total even.
  function automatic logic sel_parity(input sel_t s);
    return ^s;
  endfunction

endpackage : onehot_decoder_pkg

// File: rtl/onehot_decoder_if.sv
// Input and output handshakes of the one-hot decoder; the parity side-band
// exists only when ONEHOT_DECODER_PARITY_EN is defined.
interface onehot_decoder_if #(
  parameter int unsigned CNT_W = onehot_decoder_pkg::CNT_W
);

  logic                       in_valid;
  logic                       in_ready;
  onehot_decoder_pkg::sel_t   sel;
  logic                       out_valid;
  logic                       out_ready;
  onehot_decoder_pkg::onehot_t dout;
  logic [CNT_W-1:0]           dec_count;
`ifdef ONEHOT_DECODER_PARITY_EN
  logic                       sel_par;
  logic                       par_err;
`endif

`ifdef ONEHOT_DECODER_PARITY_EN
  modport master (
    output in_valid, sel, sel_par, out_ready,
    input  in_ready, out_valid, dout, dec_count, par_err
  );

  modport slave (
    input  in_valid, sel, sel_par, out_ready,
    output in_ready, out_valid, dout, dec_count, par_err
  );
`else
  modport master (
    output in_valid, sel, out_ready,
    input  in_ready, out_valid, dout, dec_count
  );

  modport slave (
    input  in_valid, sel, out_ready,
    output in_ready, out_valid, dout, dec_count
  );
`endif

endinterface : onehot_decoder_if

// File: rtl/onehot_fifo2.sv
// Generic 2-entry valid/ready FIFO with fully registered outputs; the pop
// data is forced to zero whenever the FIFO is empty.
module onehot_fifo2
  import onehot_decoder_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_valid_i,
  output logic              push_ready_o,
  input  logic [DATA_W-1:0] push_data_i,
  output logic              pop_valid_o,
  input  logic              pop_ready_i,
  output logic [DATA_W-1:0] pop_data_o
);

  fifo_state_e                  state_q, state_d;
  logic                         wr_ptr_q, wr_ptr_d;
  logic                         rd_ptr_q, rd_ptr_d;
  logic [1:0][DATA_W-1:0]       mem_q, mem_d;
  logic                         in_ready_q, in_ready_d;
  logic                         out_valid_q, out_valid_d;
  logic [DATA_W-1:0]            dout_q, dout_d;
  logic                         push_fire;
  logic                         pop_fire;

  assign push_fire = push_valid_i & in_ready_q;
  assign pop_fire  = out_valid_q & pop_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FIFO_EMPTY;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      mem_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_q       <= mem_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
    end
  end

  // Occupancy FSM; outputs are precomputed from the next state so they register cleanly.
  always_comb begin
    state_d  = state_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + 1'(push_fire);
    rd_ptr_d = rd_ptr_q + 1'(pop_fire);

    if (push_fire) begin
      mem_d[wr_ptr_q] = push_data_i;
    end

    unique case (state_q)
      FIFO_EMPTY: begin
        if (push_fire) state_d = FIFO_ONE;
      end
      FIFO_ONE: begin
        if (push_fire && !pop_fire)      state_d = FIFO_FULL;
        else if (pop_fire && !push_fire) state_d = FIFO_EMPTY;
      end
      FIFO_FULL: begin
        if (pop_fire) state_d = FIFO_ONE;
      end
      default: state_d = FIFO_EMPTY;
    endcase

    in_ready_d  = (state_d != FIFO_FULL);
    out_valid_d = (state_d != FIFO_EMPTY);
    dout_d      = out_valid_d ? mem_d[rd_ptr_d] : '0;
  end

  assign push_ready_o = in_ready_q;
  assign pop_valid_o  = out_valid_q;
  assign pop_data_o   = dout_q;

endmodule : onehot_fifo2

// File: rtl/onehot_decoder.sv
// Binary-to-one-hot decoder with a 2-entry output FIFO and saturating accept
// counter. Define ONEHOT_DECODER_PARITY_EN to add sel parity checking.
module onehot_decoder #(
  parameter int unsigned CNT_W = onehot_decoder_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  onehot_decoder_if.slave  bus
);

  import onehot_decoder_pkg::*;

  logic             fifo_ready;
  logic             accept;
  onehot_t          word;
  logic [CNT_W-1:0] dec_count_q, dec_count_d;

  assign accept = bus.in_valid & fifo_ready;

`ifdef ONEHOT_DECODER_PARITY_EN
  logic par_bad;
  logic par_err_q, par_err_d;

  // A bad-parity index is still accepted but decodes to an empty word.
  assign par_bad = (bus.sel_par != sel_parity(bus.sel));
  assign word    = par_bad ? '0 : onehot(bus.sel);

  always_comb begin
    par_err_d = par_err_q;
    if (accept && par_bad) par_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) par_err_q <= 1'b0;
    else       par_err_q <= par_err_d;
  end

  assign bus.par_err = par_err_q;
`else
  assign word = onehot(bus.sel);
`endif

  // Saturating count of accepted indices.
  always_comb begin
    dec_count_d = dec_count_q;
    if (accept && (dec_count_q != {CNT_W{1'b1}})) begin
      dec_count_d = dec_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) dec_count_q <= '0;
    else       dec_count_q <= dec_count_d;
  end

  onehot_fifo2 #(
    .DATA_W (OUT_W)
  ) u_fifo (
    .clk          (clk),
    .rst          (reset),
    .push_valid_i (bus.in_valid),
    .push_ready_o (fifo_ready),
    .push_data_i  (word),
    .pop_valid_o  (bus.out_valid),
    .pop_ready_i  (bus.out_ready),
    .pop_data_o   (bus.dout)
  );

  assign bus.in_ready  = fifo_ready;
  assign bus.dec_count = dec_count_q;

  sel_known_a: assert property (@(posedge clk) disable iff (reset)
    bus.in_valid |-> !$isunknown(bus.sel));

endmodule : onehot_decoder

// File: doc/onehot_decoder.md
Name: onehot_decoder

Overview:
- Binary-to-one-hot decoder; the inverse of the team's 8:3 one-hot encoder.
- Accepts a 3-bit index over a valid/ready handshake and produces the matching 8-bit one-hot word on an output valid/ready handshake.
- Outputs are buffered in a 2-entry FIFO so the downstream side can stall without losing data.
- Sits on the consumer side of the encoded-index path; regenerates select/grant vectors.

Parameters:
- SEL_W, 3, index width.
- OUT_W, 8, one-hot width; must equal 2**SEL_W.
- CNT_W, 16, width of the decoded-word counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  sel is valid this cycle.
- in_ready  output  1  block can accept sel this cycle.
- sel  input  SEL_W  binary index to decode.
- out_valid  output  1  dout holds a valid word.
- out_ready  input  1  downstream accepts dout this cycle.
- dout  output  OUT_W  one-hot word; bit[sel] = 1.
- dec_count  output  CNT_W  number of words accepted on the input since reset.

Behaviour:
- Reset (async assert, sync release) sets:
  - FIFO empty: out_valid = 0, dout = 0, in_ready = 1.
  - dec_count = 0.
- Accept: in_valid & in_ready at a clk edge pushes onehot(sel) into the FIFO.
- Decode rule: dout bit i = (sel == i); exactly one bit is set for every legal sel.
- Latency: 1 cycle. A word accepted at edge N appears on dout with out_valid = 1 after edge N, provided the FIFO was empty.
- Output handshake: out_valid & out_ready at an edge pops the head entry.
  - dout and out_valid hold stable while out_valid = 1 and out_ready = 0.
  - dout = 0 whenever out_valid = 0.
- FIFO states:
  - EMPTY: count 0; in_ready 1, out_valid 0.
  - ONE: count 1; in_ready 1, out_valid 1.
  - FULL: count 2; in_ready 0, out_valid 1.
- FIFO transitions:
  - Push only: count + 1.
  - Pop only: count - 1.
  - Push and pop in the same cycle (legal only in ONE): count unchanged; the new word becomes the head on the next cycle.
- in_ready is a registered function of FIFO count only; there is no combinational path from out_ready.
- Full: in_ready = 0. A sel presented while full is not accepted and not counted; upstream must hold it.
- Empty: a pop cannot occur because out_valid = 0; out_ready is ignored.
- FIFO pointers are 1 bit and wrap naturally.
- dec_count increments on each accept and saturates at 2**CNT_W-1 (no wrap).
- sel with X/Z in simulation: assertion fires if in_valid = 1 and sel is not known.
- Reset mid-operation flushes the FIFO; any pending words are discarded.

Optional Feature:
- Macro: ONEHOT_DECODER_PARITY_EN.
- When defined:
  - Adds input sel_par (1 bit, even parity over sel) and output par_err (1 bit, sticky).
  - A word accepted with bad parity is pushed as all-zeros (no bit set) and sets par_err to 1.
  - par_err clears only on reset.
  - Bad-parity words are still counted in dec_count.
- When undefined: neither port exists, and every accepted word decodes normally.

Decomposition:
- Package onehot_decoder_pkg holds:
  - Constants SEL_W = 3, OUT_W = 8, CNT_W = 16, FIFO_DEPTH = 2.
  - Typedefs sel_t [SEL_W-1:0] and onehot_t [OUT_W-1:0].
  - Function onehot() returning onehot_t from sel_t.
- One natural sub-module: onehot_fifo2, a generic 2-entry valid/ready FIFO parameterised on data width.
- The top level instantiates onehot_fifo2 and holds the decode logic, counter and optional parity logic.

Test Plan:
- Sweep: reset, then sel = 0..7 back-to-back with out_ready = 1 -> dout = 0x01, 0x02, 0x04 … 0x80, each 1 cycle after accept; dec_count = 8.
- Backpressure: out_ready = 0, push sel = 3, 5, 6 -> in_ready drops after 2 accepts; dout holds 0x08; sel = 6 is held by upstream. Release out_ready -> 0x08, 0x20, 0x40 in order.
- Simultaneous push/pop in ONE state with sel = 1 then 2 and out_ready = 1 -> count stays 1; dout goes 0x02 then 0x04 on consecutive cycles.
- Counter saturation: CNT_W = 4, 20 accepts -> dec_count = 0xF.
- Reset mid-operation: FIFO holding 2 words, assert reset -> out_valid = 0, dout = 0, in_ready = 1, dec_count = 0 immediately, without waiting for a clock edge.
- With ONEHOT_DECODER_PARITY_EN: sel = 3 with sel_par = 1 -> dout = 0x00 and par_err = 1; then a good-parity sel = 4 -> dout = 0x10 and par_err stays 1.
